// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath definitions: ALU control codes, the zero-register
// index and the register-index type.
package legv8_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam reg_idx_t REG_XZR = 5'd31;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding mux for one source register. XZR always reads zero,
// the younger MEM result takes precedence over the older WB result, and
// otherwise the value read from the register file at decode is used.
module fwd_mux
  import legv8_pkg::*;
#(
  parameter int N = 64
) (
  input  reg_idx_t     src,
  input  logic [N-1:0] regval,
  input  logic         mem_wen,
  input  reg_idx_t     mem_rd,
  input  logic [N-1:0] mem_data,
  input  logic         wb_wen,
  input  reg_idx_t     wb_rd,
  input  logic [N-1:0] wb_data,
  output logic [N-1:0] fwd_val
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_wen && (mem_rd == src);
  assign wb_hit  = wb_wen  && (wb_rd  == src);

  // Select the most recent producer of src, with XZR hard-wired to zero.
  always_comb begin
    fwd_val = regval;
    if (src == REG_XZR) begin
      fwd_val = '0;
    end else if (mem_hit) begin
      fwd_val = mem_data;
    end else if (wb_hit) begin
      fwd_val = wb_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding. Holds the decoded
// instruction for the EX stage and presents final ALU operands and control.
// A bubble is an invalid slot whose ALU control is pass-B and whose write
// enable is low; reset and flush both load a bubble.
module ex_operand_stage
  import legv8_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  input  logic         id_valid,
  input  reg_idx_t     id_rn,
  input  reg_idx_t     id_rm,
  input  reg_idx_t     id_rd,
  input  logic [N-1:0] id_rd1,
  input  logic [N-1:0] id_rd2,
  input  logic [N-1:0] id_imm,
  input  logic         id_alusrc,
  input  logic [3:0]   id_aluctl,
  input  logic         id_regwrite,
  input  logic         mem_wen,
  input  logic         wb_wen,
  input  reg_idx_t     mem_rd,
  input  reg_idx_t     wb_rd,
  input  logic [N-1:0] mem_data,
  input  logic [N-1:0] wb_data,
  output logic         ex_valid,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_control,
  output logic [N-1:0] ex_store_data,
  output reg_idx_t     ex_rd,
  output logic         ex_regwrite
);

  logic         valid_q;
  reg_idx_t     rn_q;
  reg_idx_t     rm_q;
  reg_idx_t     rd_q;
  logic [N-1:0] rd1_q;
  logic [N-1:0] rd2_q;
  logic [N-1:0] imm_q;
  logic         alusrc_q;
  logic [3:0]   aluctl_q;
  logic         regwrite_q;

  logic [N-1:0] fwd_rn;
  logic [N-1:0] fwd_rm;

  // Pipeline register: reset and flush load a bubble, stall holds, else load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      rn_q       <= '0;
      rm_q       <= '0;
      rd_q       <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      aluctl_q   <= ALU_PASSB;
      regwrite_q <= 1'b0;
    end else if (flush) begin
      valid_q    <= 1'b0;
      rn_q       <= '0;
      rm_q       <= '0;
      rd_q       <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      aluctl_q   <= ALU_PASSB;
      regwrite_q <= 1'b0;
    end else if (!stall) begin
      valid_q    <= id_valid;
      rn_q       <= id_rn;
      rm_q       <= id_rm;
      rd_q       <= id_rd;
      rd1_q      <= id_rd1;
      rd2_q      <= id_rd2;
      imm_q      <= id_imm;
      alusrc_q   <= id_alusrc;
      aluctl_q   <= id_aluctl;
      regwrite_q <= id_regwrite & id_valid;
    end
  end

  fwd_mux #(.N(N)) u_fwd_rn (
    .src      (rn_q),
    .regval   (rd1_q),
    .mem_wen  (mem_wen),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .wb_wen   (wb_wen),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .fwd_val  (fwd_rn)
  );

  fwd_mux #(.N(N)) u_fwd_rm (
    .src      (rm_q),
    .regval   (rd2_q),
    .mem_wen  (mem_wen),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .wb_wen   (wb_wen),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .fwd_val  (fwd_rm)
  );

  // Operand select: B takes the immediate when alusrc is set; store data
  // always carries the forwarded rm value.
  always_comb begin
    alu_a         = fwd_rn;
    alu_b         = alusrc_q ? imm_q : fwd_rm;
    ex_store_data = fwd_rm;
  end

  assign ex_valid    = valid_q;
  assign alu_control = aluctl_q;
  assign ex_rd       = rd_q;
  assign ex_regwrite = regwrite_q & valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural slot model.
module tb_ex_operand_stage;

  localparam int N = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall, flush;
  logic          id_valid;
  logic [4:0]    id_rn, id_rm, id_rd;
  logic [N-1:0]  id_rd1, id_rd2, id_imm;
  logic          id_alusrc;
  logic [3:0]    id_aluctl;
  logic          id_regwrite;
  logic          mem_wen, wb_wen;
  logic [4:0]    mem_rd, wb_rd;
  logic [N-1:0]  mem_data, wb_data;
  logic          ex_valid;
  logic [N-1:0]  alu_a, alu_b, ex_store_data;
  logic [3:0]    alu_control;
  logic [4:0]    ex_rd;
  logic          ex_regwrite;

  ex_operand_stage #(.N(N)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_aluctl(id_aluctl), .id_regwrite(id_regwrite),
    .mem_wen(mem_wen), .wb_wen(wb_wen), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_data(mem_data), .wb_data(wb_data),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model of the instruction currently sitting in the EX slot.
  typedef struct {
    bit          valid;
    bit [4:0]    rn, rm, rd;
    bit [N-1:0]  rd1, rd2, imm;
    bit          alusrc;
    bit [3:0]    aluctl;
    bit          wr;
  } slot_t;

  slot_t m;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_bubble();
    m = '{valid: 0, rn: 0, rm: 0, rd: 0, rd1: 0, rd2: 0, imm: 0,
          alusrc: 0, aluctl: 4'b0111, wr: 0};
  endfunction

  // Value an instruction sees for register s, given what it read at decode.
  function automatic logic [N-1:0] operand(input bit [4:0] s, input bit [N-1:0] v);
    if (s == 5'd31) return '0;
    if (mem_wen && mem_rd == s) return mem_data;
    if (wb_wen && wb_rd == s) return wb_data;
    return v;
  endfunction

  task automatic model_edge();
    if (reset || flush) model_bubble();
    else if (!stall) begin
      m.valid  = id_valid;
      m.rn     = id_rn;
      m.rm     = id_rm;
      m.rd     = id_rd;
      m.rd1    = id_rd1;
      m.rd2    = id_rd2;
      m.imm    = id_imm;
      m.alusrc = id_alusrc;
      m.aluctl = id_aluctl;
      m.wr     = id_regwrite && id_valid;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, N'(ex_valid), N'(m.valid));
    check({tag, ".alu_a"}, alu_a, operand(m.rn, m.rd1));
    check({tag, ".alu_b"}, alu_b, m.alusrc ? m.imm : operand(m.rm, m.rd2));
    check({tag, ".store"}, ex_store_data, operand(m.rm, m.rd2));
    check({tag, ".ctl"}, N'(alu_control), N'(m.aluctl));
    check({tag, ".rd"}, N'(ex_rd), N'(m.rd));
    check({tag, ".wr"}, N'(ex_regwrite), N'(m.wr));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic drive_id(input bit v, input bit [4:0] rn, input bit [4:0] rm,
                          input bit [4:0] rd, input bit [N-1:0] d1, input bit [N-1:0] d2,
                          input bit [N-1:0] imm, input bit src, input bit [3:0] ctl,
                          input bit wr);
    id_valid = v; id_rn = rn; id_rm = rm; id_rd = rd; id_rd1 = d1; id_rd2 = d2;
    id_imm = imm; id_alusrc = src; id_aluctl = ctl; id_regwrite = wr;
  endtask

  function automatic bit [4:0] pick_reg();
    if ($urandom_range(0, 4) == 0) return 5'd31;
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic bit [N-1:0] rnd64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  task automatic rand_fwd();
    mem_wen  = 1'($urandom_range(0, 1));
    wb_wen   = 1'($urandom_range(0, 1));
    mem_rd   = pick_reg();
    wb_rd    = pick_reg();
    mem_data = rnd64();
    wb_data  = rnd64();
  endtask

  initial begin
    reset = 1'b1; stall = 0; flush = 0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_wen = 0; wb_wen = 0; mem_rd = 0; wb_rd = 0; mem_data = 0; wb_data = 0;
    model_bubble();
    #2;
    check_all("reset");
    check("reset.ctl_const", N'(alu_control), N'(4'b0111));
    // Forwarding stays live in reset: registered rn is r0.
    mem_wen = 1; mem_rd = 5'd0; mem_data = 64'h1234;
    #1;
    check("reset.fwd_r0", alu_a, 64'h1234);
    mem_wen = 0;
    #1;
    reset = 1'b0;

    // Plain load, no forwarding.
    drive_id(1, 1, 2, 9, 5, 7, 0, 0, 4'b0010, 1);
    cycle();
    check_all("load");
    check("load.a_const", alu_a, 64'd5);
    check("load.b_const", alu_b, 64'd7);
    check("load.ctl_const", N'(alu_control), N'(4'b0010));

    // MEM beats WB, then WB alone.
    drive_id(1, 3, 4, 5, 64'h11, 64'h22, 0, 0, 4'b0000, 1);
    cycle();
    mem_wen = 1; mem_rd = 3; mem_data = 64'hAA;
    wb_wen = 1; wb_rd = 3; wb_data = 64'hBB;
    #1;
    check("fwd.mem_wins", alu_a, 64'hAA);
    mem_wen = 0;
    #1;
    check("fwd.wb", alu_a, 64'hBB);
    check_all("fwd");
    wb_wen = 0;

    // XZR never forwards.
    drive_id(1, 31, 31, 1, 64'h55, 64'h66, 0, 0, 4'b0001, 1);
    cycle();
    mem_wen = 1; mem_rd = 31; mem_data = 64'hFF;
    #1;
    check("xzr.a", alu_a, 64'd0);
    check_all("xzr");
    mem_wen = 0;

    // Immediate on B, store data still forwarded.
    drive_id(1, 2, 4, 6, 64'h1, 64'h2, -64'sd4, 1, 4'b0010, 0);
    cycle();
    wb_wen = 1; wb_rd = 4; wb_data = 64'd9;
    #1;
    check("imm.b", alu_b, 64'hFFFF_FFFF_FFFF_FFFC);
    check("imm.store", ex_store_data, 64'd9);
    check_all("imm");
    wb_wen = 0;

    // Stall holds while decode changes; stall+flush inserts a bubble.
    drive_id(1, 5, 6, 7, 64'hA0, 64'hB0, 64'hC0, 0, 4'b0110, 1);
    cycle();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      drive_id(1, 1, 1, 1, rnd64(), rnd64(), rnd64(), 1, 4'b0001, 1);
      cycle();
      check("stall.a", alu_a, 64'hA0);
      check("stall.rd", N'(ex_rd), N'(5'd7));
      check_all("stall");
    end
    flush = 1;
    cycle();
    check("flush.valid", N'(ex_valid), '0);
    check("flush.wr", N'(ex_regwrite), '0);
    check("flush.ctl", N'(alu_control), N'(4'b0111));
    check_all("flush");
    stall = 0; flush = 0;

    // Asynchronous reset mid-cycle.
    drive_id(1, 2, 3, 4, 64'h77, 64'h88, 0, 0, 4'b0010, 1);
    cycle();
    reset = 1;
    model_bubble();
    #1;
    check("areset.valid", N'(ex_valid), '0);
    check("areset.a", alu_a, '0);
    check("areset.ctl", N'(alu_control), N'(4'b0111));
    check_all("areset");
    // Release during a stall: first edge keeps the bubble.
    stall = 1;
    reset = 0;
    cycle();
    check_all("rel_stall");
    stall = 0;

    // Invalid instruction never writes.
    drive_id(0, 1, 2, 3, 64'h1, 64'h2, 0, 0, 4'b0010, 1);
    cycle();
    check("inval.wr", N'(ex_regwrite), '0);
    check_all("inval");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive_id(1'($urandom_range(0, 3) != 0), pick_reg(), pick_reg(), pick_reg(),
               rnd64(), rnd64(), rnd64(), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      if (reset) reset = 0;
      else if ($urandom_range(0, 29) == 0) begin
        reset = 1;
        model_bubble();
      end
      rand_fwd();
      #1;
      check_all("rnd.pre");
      cycle();
      check_all("rnd.edge");
      rand_fwd();
      #1;
      check_all("rnd.fwd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-forwarding stage that feeds the 64-bit ALU in the pipelined LEGv8 datapath. Captures decoded operands and controls each cycle, resolves read-after-write hazards by forwarding results from the MEM and WB stages, and presents final A/B operands plus the 4-bit ALU control to the ALU. Supports stall (hold) and flush (bubble insertion) from the hazard unit.

## Interface
Parameters:
- N, 64, datapath width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold current contents
- flush  in  1  load a bubble
- id_valid  in  1  decode slot holds a real instruction
- id_rn, id_rm, id_rd  in  5 each  source and destination register numbers
- id_rd1, id_rd2  in  N  register-file read data for rn and rm
- id_imm  in  N  sign-extended immediate
- id_alusrc  in  1  1 selects imm as B
- id_aluctl  in  4  ALU control code
- id_regwrite  in  1  instruction writes rd
- mem_wen, wb_wen  in  1 each  MEM/WB stage will write its rd
- mem_rd, wb_rd  in  5 each  MEM/WB destination register
- mem_data, wb_data  in  N  MEM/WB result value
- ex_valid  out  1  EX slot holds a real instruction
- alu_a, alu_b  out  N  ALU operands (after forwarding and immediate select)
- alu_control  out  4  ALU control
- ex_store_data  out  N  forwarded rm value for stores (never immediate)
- ex_rd  out  5  destination register
- ex_regwrite  out  1  qualified write enable: id_regwrite AND valid

## Operation
- Registered fields: valid, rn, rm, rd, rd1, rd2, imm, alusrc, aluctl, regwrite.
- Each edge, priority: reset > flush > stall > load.
  - flush: valid=0, every payload field zero, aluctl=4'b0111 (pass B), regwrite=0.
  - stall: all fields hold.
  - load: capture id_* inputs; regwrite captured as id_regwrite & id_valid.
- Forwarding is combinational from the registered fields to the outputs. For source s ∈ {rn, rm}:
  - s==31 (XZR): operand = 0 (no forwarding).
  - else if mem_wen && mem_rd==s: mem_data.
  - else if wb_wen && wb_rd==s: wb_data.
  - else the registered rd1/rd2.
- MEM beats WB when both match.
- alu_a = forwarded rn value. alu_b = alusrc ? imm : forwarded rm value. ex_store_data = forwarded rm value regardless of alusrc.
- ex_valid=0 does not zero the operands. The downstream stage qualifies on ex_valid/ex_regwrite.
- No arithmetic is performed. Widths pass through unchanged.

## Timing
- Reset (async, immediate): ex_valid=0, ex_regwrite=0, ex_rd=0, alu_control=4'b0111, alu_a=0, alu_b=0, ex_store_data=0. The forwarding path is still live: a matching mem/wb write to r0 during reset drives its data onto alu_a, because registered rn=0.
- Latency: 1 cycle from id_* to outputs. Forwarding adds 0 cycles.
- stall and flush asserted together: flush wins.
- Reset deasserted mid-stall: first edge after release applies stall to the reset (bubble) contents.
- Outputs change only on a clock edge, on reset, or when mem_*/wb_* inputs change.

## Structure
- Shared package legv8_pkg:
  - ALU control constants ALU_AND=4'b0000, ALU_ORR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_PASSB=4'b0111.
  - Constant REG_XZR=5'd31.
  - Typedef reg_idx_t (logic[4:0]).
- One sub-module, fwd_mux: inputs src index, registered value, mem/wb write info; output forwarded value. Instantiated twice (rn, rm).

## Test plan
- Reset, then load rn=1, rm=2, rd1=5, rd2=7, alusrc=0, aluctl=ADD, no forwarding enables → next cycle alu_a=5, alu_b=7, alu_control=4'b0010, ex_valid=1.
- Registered rn=3, mem_wen=1, mem_rd=3, mem_data=0xAA, wb_wen=1, wb_rd=3, wb_data=0xBB → alu_a=0xAA. Drop mem_wen → alu_a=0xBB.
- rn=31, mem_wen=1, mem_rd=31, mem_data=0xFF → alu_a=0.
- alusrc=1, imm=-4, rm forwarded from WB as 9 → alu_b=0xFFFF_FFFF_FFFF_FFFC, ex_store_data=9.
- Load instruction A, then stall for 2 cycles while id_* changes → outputs hold A. Then stall=1 with flush=1 → ex_valid=0, ex_regwrite=0, alu_control=4'b0111.
- Assert reset asynchronously mid-cycle with valid contents → outputs reach reset values before the next edge. Load with id_valid=0, id_regwrite=1 → ex_regwrite=0.
